mul_core_ctrl: RTL and testbench
================================

Name: mul_core_ctrl

Overview:
- Sequencer wrapping one mul_core instance: on a run command it streams N operand pairs from an operand SRAM, multiplies them, and writes N products to a result SRAM.
- Sits between the host/control register block (run, count, status) and two single-port synchronous SRAMs.
- Throughput is one product per cycle. Fixed pipeline: SRAM read, then multiply, then write.

Parameters:
- IN_DATA_WIDTH, 8, operand width; product width is 2*IN_DATA_WIDTH.
- ADDR_WIDTH, 7, SRAM address width; max run length 2**ADDR_WIDTH.
- CNT_BIT, 8, width of the requested pair count; must satisfy CNT_BIT >= ADDR_WIDTH+1.

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_run  in  1  start pulse; sampled only in IDLE.
- i_num_cnt  in  CNT_BIT  number of pairs to process; latched on accepted i_run.
- o_idle  out  1  high in IDLE.
- o_running  out  1  high in RUN.
- o_done  out  1  one-cycle pulse in DONE.
- o_addr0  out  ADDR_WIDTH  operand SRAM address.
- o_ce0  out  1  operand SRAM read enable.
- i_q0  in  2*IN_DATA_WIDTH  operand SRAM read data, 1-cycle latency; a = upper half, b = lower half.
- o_addr1  out  ADDR_WIDTH  result SRAM address.
- o_ce1  out  1  result SRAM enable.
- o_we1  out  1  result SRAM write enable.
- o_d1  out  2*IN_DATA_WIDTH  product to write.

Behaviour:
- Reset (synchronous, active-high) values:
  - State is IDLE.
  - o_idle=1.
  - o_running=0, o_done=0.
  - All address, ce, we and data outputs are 0.
  - Counters cleared.
- The internal mul_core reset_n is driven by ~reset.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - i_run=1 latches i_num_cnt into r_num.
  - If i_num_cnt==0, go to DONE with no SRAM access.
  - Otherwise go to RUN.
- RUN:
  - The read counter rd_cnt issues o_ce0=1 with o_addr0=rd_cnt, one per cycle, until rd_cnt reaches r_num-1. No further reads after that.
  - i_q0 is valid the cycle after a read. That cycle it drives mul_core i_valid, with i_a=i_q0[upper] and i_b=i_q0[lower].
  - The mul_core o_valid cycle drives o_ce1=o_we1=1, o_addr1=wr_cnt, o_d1=o_result (unsigned product), and increments wr_cnt.
  - When the write with wr_cnt==r_num-1 is issued, go to DONE.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- Timing: with i_run accepted at cycle 0, reads occur in cycles 1..N, writes in cycles 3..N+2, and o_done in cycle N+3.
- i_run in RUN or DONE is ignored. i_num_cnt changes after acceptance have no effect.
- o_we1 is only asserted in RUN.
- Reset mid-run:
  - Returns to IDLE on the next edge.
  - No write occurs in or after the reset cycle; in-flight products are discarded.
  - No o_done is produced.
- i_num_cnt > 2**ADDR_WIDTH: clamped to 2**ADDR_WIDTH. Addresses never wrap.
- Back-to-back runs: i_run in the first IDLE cycle after DONE is accepted.

Decomposition:
- Package mul_core_ctrl_pkg holds:
  - State encoding: S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - The pipeline depth constant PIPE_LAT=2 (read plus multiply).
- One sub-module: mul_core (1-cycle registered multiplier), instantiated unchanged.
- All counters and the FSM live in mul_core_ctrl.

Test Plan:
- N=4; operand SRAM {0x0203, 0x0A0B, 0xFFFF, 0x0010} -> result SRAM {0x0006, 0x006E, 0xFE01, 0x0000}; four writes in cycles 3..6; o_done in cycle 7; o_idle back at 1 in cycle 8.
- N=0 -> no o_ce0/o_we1 activity; o_done pulses in cycle 1; IDLE in cycle 2.
- N=3 with i_run re-asserted in every RUN cycle and i_num_cnt changed to 9 -> exactly 3 writes; single o_done.
- N=8, reset asserted in cycle 4 -> o_we1=0 from cycle 4 onward; no o_done; o_idle=1 after the reset edge; a following run of N=2 completes correctly.
- N=128 (full range) with operand i = {i, i+1} -> every result[i] = i*(i+1); last write at address 127; o_done in cycle 131.
- Two back-to-back runs (N=2, then N=3, the second i_run the cycle after o_done) -> results correct; second o_done 6 cycles after its start.

Source files
------------

// File: rtl/mul_core_ctrl_pkg.sv
// Shared types and constants for the mul_core_ctrl sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_core_ctrl_pkg;

  // Sequencer states; the encoding is visible on debug taps, so keep it fixed.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Cycles from an operand read being issued to its product being presented:
  // one for the SRAM read, one for the registered multiplier.
  localparam int PIPE_LAT = 2;

endpackage

// File: rtl/mul_core.sv
// Registered unsigned multiplier: o_result = i_a * i_b.
// Latency: 1 cycle from i_valid to o_valid.
// Backpressure: none, accepts one operand pair per cycle unconditionally.
// Ports: clk, reset_n (synchronous, active-low), i_valid/i_a/i_b in,
//        o_valid/o_result out (2*IN_DATA_WIDTH wide).
module mul_core #(
  parameter int IN_DATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_valid,
  input  logic [IN_DATA_WIDTH-1:0]   i_a,
  input  logic [IN_DATA_WIDTH-1:0]   i_b,
  output logic                       o_valid,
  output logic [2*IN_DATA_WIDTH-1:0] o_result
);

  // Zero-extend first so the multiply is carried out at full product width.
  logic [2*IN_DATA_WIDTH-1:0] a_ext, b_ext;
  assign a_ext = {{IN_DATA_WIDTH{1'b0}}, i_a};
  assign b_ext = {{IN_DATA_WIDTH{1'b0}}, i_b};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_valid  <= 1'b0;
      o_result <= '0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_result <= a_ext * b_ext;
      end
    end
  end

endmodule

// File: rtl/mul_core_ctrl.sv
// Run sequencer: streams N operand pairs from SRAM0 through mul_core into SRAM1.
// Latency: reads in cycles 1..N, writes in cycles 3..N+2, o_done in cycle N+3.
// Backpressure: none; one product per cycle, i_run ignored outside IDLE.
// Ports: clk, reset (sync, active-high); control i_run, i_num_cnt, o_idle,
//        o_running, o_done; operand SRAM o_addr0/o_ce0/i_q0; result SRAM
//        o_addr1/o_ce1/o_we1/o_d1.
module mul_core_ctrl
  import mul_core_ctrl_pkg::*;
#(
  parameter int IN_DATA_WIDTH = 8,
  parameter int ADDR_WIDTH    = 7,
  parameter int CNT_BIT       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_run,
  input  logic [CNT_BIT-1:0]         i_num_cnt,
  output logic                       o_idle,
  output logic                       o_running,
  output logic                       o_done,
  output logic [ADDR_WIDTH-1:0]      o_addr0,
  output logic                       o_ce0,
  input  logic [2*IN_DATA_WIDTH-1:0] i_q0,
  output logic [ADDR_WIDTH-1:0]      o_addr1,
  output logic                       o_ce1,
  output logic                       o_we1,
  output logic [2*IN_DATA_WIDTH-1:0] o_d1
);

  localparam int DW = 2 * IN_DATA_WIDTH;
  localparam logic [CNT_BIT-1:0] MAX_RUN = CNT_BIT'(2 ** ADDR_WIDTH);

  state_t               state;
  logic [CNT_BIT-1:0]   rd_cnt;     // address of the read currently presented
  logic [CNT_BIT-1:0]   wr_cnt;     // address of the next product to write
  logic [CNT_BIT-1:0]   r_last;     // index of the final pair of this run
  logic                 rd_en;      // a read is being presented this cycle
  logic                 q_vld;      // i_q0 carries data from last cycle's read
  logic                 mc_vld;
  logic [DW-1:0]        mc_res;
  logic [CNT_BIT-1:0]   num_clamped;
  logic [CNT_BIT-1:0]   num_last;
  logic                 wr_fire;

  // Oversized requests are clamped so addresses never wrap.
  always_comb begin
    num_clamped = (i_num_cnt > MAX_RUN) ? MAX_RUN : i_num_cnt;
    num_last    = num_clamped - CNT_BIT'(1);
  end

  mul_core #(
    .IN_DATA_WIDTH(IN_DATA_WIDTH)
  ) u_mul_core (
    .clk      (clk),
    .reset_n  (~reset),
    .i_valid  (q_vld),
    .i_a      (i_q0[DW-1:IN_DATA_WIDTH]),
    .i_b      (i_q0[IN_DATA_WIDTH-1:0]),
    .o_valid  (mc_vld),
    .o_result (mc_res)
  );

  // Writes are qualified with reset directly so that a reset cycle in the
  // middle of a run never lets an in-flight product reach the result SRAM.
  assign wr_fire = mc_vld && (state == S_RUN) && !reset;

  assign o_ce0   = rd_en;
  assign o_addr0 = rd_cnt[ADDR_WIDTH-1:0];
  assign o_ce1   = wr_fire;
  assign o_we1   = wr_fire;
  assign o_addr1 = wr_fire ? wr_cnt[ADDR_WIDTH-1:0] : '0;
  assign o_d1    = wr_fire ? mc_res : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      o_idle    <= 1'b1;
      o_running <= 1'b0;
      o_done    <= 1'b0;
      rd_en     <= 1'b0;
      q_vld     <= 1'b0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      r_last    <= '0;
    end else begin
      q_vld <= rd_en;
      case (state)
        S_IDLE: begin
          if (i_run) begin
            r_last <= num_last;
            rd_cnt <= '0;
            wr_cnt <= '0;
            o_idle <= 1'b0;
            if (i_num_cnt == '0) begin
              // Empty run: report completion without touching either SRAM.
              state  <= S_DONE;
              o_done <= 1'b1;
            end else begin
              state     <= S_RUN;
              o_running <= 1'b1;
              rd_en     <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (rd_en) begin
            if (rd_cnt == r_last) begin
              rd_en <= 1'b0;
            end else begin
              rd_cnt <= rd_cnt + CNT_BIT'(1);
            end
          end
          if (wr_fire) begin
            wr_cnt <= wr_cnt + CNT_BIT'(1);
            if (wr_cnt == r_last) begin
              state     <= S_DONE;
              o_running <= 1'b0;
              o_done    <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_done <= 1'b0;
          o_idle <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          o_idle    <= 1'b1;
          o_running <= 1'b0;
          o_done    <= 1'b0;
          rd_en     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_core_ctrl.sv
// Scoreboard bench for mul_core_ctrl: stimulus pushes expected writes and the
// done pulse (with their cycle stamps) into a queue; a negedge monitor pops
// and compares whatever the DUT presents.
module tb_mul_core_ctrl;
  import mul_core_ctrl_pkg::*;

  localparam int W    = 8;
  localparam int AW   = 7;
  localparam int CB   = 8;
  localparam int DW   = 2 * W;
  localparam int MAXN = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_run = 1'b0;
  logic [CB-1:0] i_num_cnt = '0;
  logic [DW-1:0] i_q0 = '0;
  logic          o_idle, o_running, o_done, o_ce0, o_ce1, o_we1;
  logic [AW-1:0] o_addr0, o_addr1;
  logic [DW-1:0] o_d1;

  mul_core_ctrl #(.IN_DATA_WIDTH(W), .ADDR_WIDTH(AW), .CNT_BIT(CB)) dut (
    .clk(clk), .reset(reset), .i_run(i_run), .i_num_cnt(i_num_cnt),
    .o_idle(o_idle), .o_running(o_running), .o_done(o_done),
    .o_addr0(o_addr0), .o_ce0(o_ce0), .i_q0(i_q0),
    .o_addr1(o_addr1), .o_ce1(o_ce1), .o_we1(o_we1), .o_d1(o_d1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM models
  logic [DW-1:0] op_mem [MAXN];
  logic [DW-1:0] res_mem[MAXN];
  always @(posedge clk) if (o_ce0) i_q0 <= op_mem[o_addr0];
  always @(posedge clk) if (o_ce1 && o_we1) res_mem[o_addr1] <= o_d1;

  typedef struct {
    bit is_done;
    int addr;
    int data;
    int cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int n_cmp = 0;
  int n_err = 0;
  int rd_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (o_ce0 === 1'b1) begin
      check("rd_addr", 32'(o_addr0), rd_seen);
      rd_seen++;
    end
    if (o_we1 === 1'b1) check("we_only_in_run", 32'(o_running), 1);
    if (o_ce1 === 1'b1 && o_we1 === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected", o_addr1, o_d1);
      end else begin
        e = sb.pop_front();
        check("wr_kind", 32'(e.is_done), 0);
        check("wr_addr", 32'(o_addr1), e.addr);
        check("wr_data", 32'(o_d1), e.data);
        check("wr_cycle", cyc, e.cyc);
      end
    end
    if (o_done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_done: o_done high, none expected");
      end else begin
        e = sb.pop_front();
        check("done_kind", 32'(e.is_done), 1);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue one run starting in the current cycle (called #1 after an edge).
  // abort_at >= 0 asserts reset during that relative cycle.
  task automatic run_cmd(input int n, input bit spam, input int abort_at);
    int ne, start, done_rel, c, a, b;
    ne       = (n > MAXN) ? MAXN : n;
    start    = cyc;
    done_rel = (ne == 0) ? 1 : ne + PIPE_LAT + 1;
    rd_seen  = 0;
    for (int i = 0; i < ne; i++) begin
      if (abort_at < 0 || (PIPE_LAT + 1 + i) < abort_at) begin
        a = int'(op_mem[i][DW-1:W]);
        b = int'(op_mem[i][W-1:0]);
        sb.push_back('{1'b0, i, (a * b) & 32'hFFFF, start + PIPE_LAT + 1 + i});
      end
    end
    if (abort_at < 0) sb.push_back('{1'b1, 0, 0, start + done_rel});
    i_run     = 1'b1;
    i_num_cnt = n[CB-1:0];
    @(posedge clk); #1;
    for (c = 1; c < 400; c++) begin
      if (o_idle === 1'b1) break;
      i_run = spam && (c <= ne + PIPE_LAT);
      if (spam) i_num_cnt = 8'd9;
      if (c == abort_at) reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
    end
    i_run = 1'b0;
    if (abort_at >= 0) begin
      check("abort_idle_cycle", c, abort_at + 1);
      check("abort_no_running", 32'(o_running), 0);
    end else begin
      check("idle_cycle", c, done_rel + 1);
      check("read_count", rd_seen, ne);
    end
    check("queue_drained", sb.size(), 0);
    sb.delete();
  endtask

  task automatic fill_random();
    for (int i = 0; i < MAXN; i++) op_mem[i] = DW'($urandom);
  endtask

  logic [DW-1:0] t4_op [4];
  logic [DW-1:0] t4_res[4];

  initial begin
    t4_op  = '{16'h0203, 16'h0A0B, 16'hFFFF, 16'h0010};
    t4_res = '{16'h0006, 16'h006E, 16'hFE01, 16'h0000};
    fill_random();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_idle", 32'(o_idle), 1);
    check("rst_running", 32'(o_running), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_ce0", 32'(o_ce0), 0);
    check("rst_addr0", 32'(o_addr0), 0);
    check("rst_ce1", 32'(o_ce1), 0);
    check("rst_we1", 32'(o_we1), 0);
    check("rst_addr1", 32'(o_addr1), 0);
    check("rst_d1", 32'(o_d1), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Fixed N=4 table
    for (int i = 0; i < 4; i++) op_mem[i] = t4_op[i];
    run_cmd(4, 1'b0, -1);
    for (int i = 0; i < 4; i++) check("t4_result", 32'(res_mem[i]), 32'(t4_res[i]));

    // Empty run
    run_cmd(0, 1'b0, -1);

    // i_run spam and i_num_cnt change during the run
    fill_random();
    run_cmd(3, 1'b1, -1);

    // Reset in cycle 4 of an N=8 run, then a short clean run
    run_cmd(8, 1'b0, 4);
    run_cmd(2, 1'b0, -1);

    // Full range
    for (int i = 0; i < MAXN; i++) op_mem[i] = {8'(i), 8'(i + 1)};
    run_cmd(MAXN, 1'b0, -1);
    check("full_last", 32'(res_mem[MAXN-1]), (MAXN - 1) * MAXN);

    // Back-to-back runs
    fill_random();
    run_cmd(2, 1'b0, -1);
    run_cmd(3, 1'b0, -1);

    // Randomized runs, including clamped lengths and idle gaps
    for (int k = 0; k < 12; k++) begin
      fill_random();
      run_cmd(int'($urandom_range(0, 200)), 1'($urandom_range(0, 1)), -1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
